// File: rtl/eeg_wram_sched.sv
// eeg_wram_sched: round-robin scheduler that serialises two requesters onto one WRAM configuration port.
// Optional S_RUN timeout watchdog is built when WRAM_SCHED_TIMEOUT_EN is defined.
module eeg_wram_sched #(
    parameter int WRAM_CMD_DW = 6,
    parameter int WRAM_NUM_DW = 4,
    parameter int TMO_CW      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               REQ_VLD,
    output logic [1:0]               REQ_RDY,
    input  logic [2*WRAM_CMD_DW-1:0] REQ_CMD,
    input  logic [2*WRAM_NUM_DW-1:0] REQ_IDX,
    output logic [1:0]               DONE_VLD,
    output logic                     DONE_ERR,
    output logic                     CFG_INFO_VLD,
    input  logic                     CFG_INFO_RDY,
    output logic [WRAM_CMD_DW-1:0]   CFG_INFO_CMD,
    output logic [WRAM_NUM_DW-1:0]   CFG_WRAM_IDX,
    input  logic                     WRAM_IS_IDLE,
    input  logic [TMO_CW-1:0]        TMO_LIMIT,
    output logic                     SCHED_IDLE,
    output logic                     TMO_FLAG
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_RESP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_last;
    logic                   r_owner;
    logic                   r_err;
    logic                   r_run_first;
    logic [WRAM_CMD_DW-1:0] r_cmd;
    logic [WRAM_NUM_DW-1:0] r_idx;

    logic                   w_winner;
    logic                   w_accept;
    logic [WRAM_CMD_DW-1:0] w_sel_cmd;
    logic [WRAM_NUM_DW-1:0] w_sel_idx;
    logic                   w_legal;
    logic                   w_handshake;
    logic                   w_wram_done;
    logic                   w_tmo_hit;
    logic                   w_err_next;

    // On contention the requester that was not served last wins.
    assign w_winner    = (REQ_VLD == 2'b11) ? ~r_last : REQ_VLD[1];
    assign w_accept    = (r_state == S_IDLE) && (REQ_VLD != 2'b00);
    assign w_sel_cmd   = w_winner ? REQ_CMD[2*WRAM_CMD_DW-1:WRAM_CMD_DW] : REQ_CMD[WRAM_CMD_DW-1:0];
    assign w_sel_idx   = w_winner ? REQ_IDX[2*WRAM_NUM_DW-1:WRAM_NUM_DW] : REQ_IDX[WRAM_NUM_DW-1:0];
    assign w_legal     = $onehot(w_sel_cmd) && !w_sel_cmd[0];
    assign w_handshake = (r_state == S_ISSUE) && CFG_INFO_RDY;
    // WRAM_IS_IDLE still reflects the previous command during the first S_RUN cycle.
    assign w_wram_done = (r_state == S_RUN) && !r_run_first && WRAM_IS_IDLE;

`ifdef WRAM_SCHED_TIMEOUT_EN
    logic [TMO_CW-1:0] r_tmo_cnt;
    logic              r_tmo_flag;

    assign w_tmo_hit = (r_state == S_RUN) && (TMO_LIMIT != '0) &&
                       (r_tmo_cnt == TMO_LIMIT - TMO_CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt  <= '0;
            r_tmo_flag <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_CW'(1);
            end
            if (w_tmo_hit && !w_wram_done) begin
                r_tmo_flag <= 1'b1;
            end
        end
    end

    assign TMO_FLAG = r_tmo_flag;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TMO_LIMIT;
    assign w_tmo_hit    = 1'b0;
    assign TMO_FLAG     = 1'b0;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no latch is inferred.
        w_next     = r_state;
        w_err_next = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next     = w_legal ? S_ISSUE : S_RESP;
                    w_err_next = !w_legal;
                end
            end
            S_ISSUE: begin
                if (CFG_INFO_RDY) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_wram_done) begin
                    w_next     = S_RESP;
                    w_err_next = 1'b0;
                end else if (w_tmo_hit) begin
                    w_next     = S_RESP;
                    w_err_next = 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_err       <= 1'b0;
            r_run_first <= 1'b0;
            r_cmd       <= '0;
            r_idx       <= '0;
        end else begin
            r_state     <= w_next;
            r_err       <= w_err_next;
            r_run_first <= w_handshake;
            if (w_accept) begin
                r_owner <= w_winner;
                r_last  <= w_winner;
                r_cmd   <= w_sel_cmd;
                r_idx   <= w_sel_idx;
            end
        end
    end

    // The state register is already S_IDLE under reset; rst masks the grant combinationally.
    assign REQ_RDY      = (w_accept && !rst) ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
    assign SCHED_IDLE   = (r_state == S_IDLE);
    assign CFG_INFO_VLD = (r_state == S_ISSUE);
    assign CFG_INFO_CMD = r_cmd;
    assign CFG_WRAM_IDX = r_idx;
    assign DONE_VLD     = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign DONE_ERR     = (r_state == S_RESP) && r_err;

endmodule
